gol_gen_sequencer: RTL and testbench
====================================

// Module: gol_gen_sequencer
// PURPOSE
//  Generation sequencer for the Game-of-Life current-state register file.
//  - Walks rows 1..NROWS through a 3-row sliding window (prev/cur/nxt).
//  - Applies the Conway rule to each row and writes the new row back in place.
//  - Arbitrates the regfile write port between the host pattern loader and the engine.
//  - Sits between the host and the regfile; owns rf_ra / rf_regwrite / rf_wa / rf_wd.
// PARAMETERS
//  WIDTH    8  cells per row (regfile word width)
//  REGBITS  3  row address bits; NROWS = 2**REGBITS-1 (row 0 reads as zero)
//  GENBITS  16 generation counter width
//  WRAP     0  0: columns outside 0..WIDTH-1 are dead; 1: columns wrap (toroidal)
// PORTS
//  ph2          in   1        clock, single clock, all state updates on rising edge
//  reset_n      in   1        reset, asynchronous, active-low
//  start        in   1        request one generation; sampled only in IDLE
//  busy         out  1        high from PRIME through DONE inclusive
//  done         out  1        one-cycle pulse in DONE state
//  gen_count    out  GENBITS  completed generations, wraps modulo 2**GENBITS
//  load_valid   in   1        host row write request
//  load_ready   out  1        = (state==IDLE); load accepted when valid&ready
//  load_row     in   REGBITS  host target row
//  load_data    in   WIDTH    host row data
//  rf_ra        out  REGBITS  regfile read address
//  rf_rd        in   WIDTH    regfile read data (combinational from rf_ra)
//  rf_regwrite  out  1        regfile write enable
//  rf_wa        out  REGBITS  regfile write address
//  rf_wd        out  WIDTH    regfile write data
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, r=1, prev/cur/nxt=0, gen_count=0.
//   Outputs on reset: busy=0, done=0, rf_regwrite=0, rf_ra=0, rf_wa=0, rf_wd=0.
//   Reset mid-generation: regfile rows already written stay written; no rollback.
//  States:
//   IDLE  : load_ready=1.
//    - valid&ready with load_row!=0: rf_regwrite=1, rf_wa=load_row, rf_wd=load_data, same cycle.
//    - load_row==0: accepted, no write.
//    - start=1 -> PRIME; prev<=0, r<=1.
//    - start and load in the same cycle: load performed, start accepted; PRIME reads the loaded data.
//   PRIME : rf_ra=1; cur<=rf_rd -> LOAD.
//   LOAD  : rf_ra=(r==NROWS)?0:r+1; nxt<=rf_rd -> WRITE.
//   WRITE : rf_regwrite=1, rf_wa=r, rf_wd=rule(prev,cur,nxt).
//    - Edge: prev<=cur, cur<=nxt.
//    - If r==NROWS -> DONE, else r<=r+1 -> LOAD.
//   DONE  : done=1; gen_count<=gen_count+1 -> IDLE.
//  Outside IDLE:
//   - load_ready=0; load_valid is ignored with no write.
//   - start is ignored.
//  Latency: busy for exactly 2*NROWS+2 cycles (16 at defaults), starting the cycle after start is sampled.
//   - The DONE->IDLE cycle always elapses; start held high gives one IDLE cycle between generations.
//  Rule, per column c:
//   - n = count of the 8 neighbours in prev/cur/nxt; n is a 4-bit unsigned value, 0..8.
//   - next[c] = (n==3) | (cur[c] & n==2).
//   - Rows never wrap: row above row 1 and row below row NROWS are zero.
//   - Columns c-1 / c+1 outside the row: 0 when WRAP=0, taken modulo WIDTH when WRAP=1.
//  In-place update is safe: the old row r is held in cur, then prev, before row r+1 is computed.
//  rf_regwrite is never asserted for address 0.
// TESTING (WIDTH=8, REGBITS=3, WRAP=0 unless noted)
//  1 Blinker: load rows 2,3,4=8'h08, start -> busy 16 cycles, done pulse; row3=8'h1C, rows2,4=0, gen_count=1.
//    Start again -> rows 2,3,4=8'h08, gen_count=2.
//  2 Block / edge wrap: rows1,2=8'h03 -> unchanged after one generation.
//    WRAP=1 with rows3,4=8'h81 -> unchanged; same pattern with WRAP=0 -> rows3,4=0.
//  3 Bottom boundary: row7=8'h1C, others 0 -> row6=8'h08, row7=8'h08, others 0.
//  4 Arbitration: load_valid during busy -> load_ready=0, rf_regwrite only in WRITE cycles, data unchanged.
//    load_row=0 in IDLE -> accepted, no write.
//  5 Reset mid-run: reset_n=0 in 5th busy cycle -> busy/done/rf_regwrite=0 immediately, gen_count=0.
//    After release: IDLE, load_ready=1.
//  6 start held high with GENBITS=2: back-to-back generations, 17-cycle period; gen_count 1,2,3,0.

Source files
------------

// File: rtl/gol_gen_sequencer.sv
// Game-of-Life generation sequencer.
// Streams rows 1..NROWS of the current-state regfile through a prev/cur/nxt
// window and writes each new row back in place. The host pattern loader
// owns the regfile write port only while the sequencer is idle.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | host may load rows; start launches one generation
// PRIME | read row 1 into cur (prev is already cleared)
// LOAD  | read row r+1 into nxt (row 0 address stands in for "below NROWS")
// WRITE | write rule(prev,cur,nxt) to row r, slide window, advance r
// DONE  | one-cycle completion pulse, bump generation counter
module gol_gen_sequencer #(
  parameter int WIDTH   = 8,
  parameter int REGBITS = 3,
  parameter int GENBITS = 16,
  parameter int WRAP    = 0
) (
  input  logic               ph2,
  input  logic               reset_n,
  input  logic               start,
  output logic               busy,
  output logic               done,
  output logic [GENBITS-1:0] gen_count,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [REGBITS-1:0] load_row,
  input  logic [WIDTH-1:0]   load_data,
  output logic [REGBITS-1:0] rf_ra,
  input  logic [WIDTH-1:0]   rf_rd,
  output logic               rf_regwrite,
  output logic [REGBITS-1:0] rf_wa,
  output logic [WIDTH-1:0]   rf_wd
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PRIME = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  // Last row index is all-ones: NROWS = 2**REGBITS-1.
  localparam logic [REGBITS-1:0] NROWS   = '1;
  localparam logic [REGBITS-1:0] ROW_ONE = REGBITS'(1);

  logic [2:0]         state;
  logic [REGBITS-1:0] r;
  logic [WIDTH-1:0]   prev;
  logic [WIDTH-1:0]   cur;
  logic [WIDTH-1:0]   nxt;
  logic [WIDTH-1:0]   next_row;
  logic [WIDTH+1:0]   ext_p;
  logic [WIDTH+1:0]   ext_c;
  logic [WIDTH+1:0]   ext_n;
  logic               load_fire;

  // One guard column on each side: dead cells, or the opposite edge when toroidal.
  function automatic logic [WIDTH+1:0] pad_row(input logic [WIDTH-1:0] row);
    if (WRAP != 0) pad_row = {row[0], row, row[WIDTH-1]};
    else           pad_row = {1'b0, row, 1'b0};
  endfunction

  assign ext_p = pad_row(prev);
  assign ext_c = pad_row(cur);
  assign ext_n = pad_row(nxt);

  // Conway rule per column; ext_x[c+1] is column c, so neighbours sit at c and c+2.
  always_comb begin
    logic [3:0] n;
    n        = '0;
    next_row = '0;
    for (int c = 0; c < WIDTH; c++) begin
      n = 4'(ext_p[c]) + 4'(ext_p[c+1]) + 4'(ext_p[c+2])
        + 4'(ext_c[c])                  + 4'(ext_c[c+2])
        + 4'(ext_n[c]) + 4'(ext_n[c+1]) + 4'(ext_n[c+2]);
      next_row[c] = (n == 4'd3) | (cur[c] & (n == 4'd2));
    end
  end

  assign load_ready = (state == S_IDLE);
  // Held off while reset is asserted so no stray write escapes during reset.
  assign load_fire  = load_valid & load_ready & reset_n;

  // Status and regfile port decode from the current state.
  always_comb begin
    busy        = (state != S_IDLE);
    done        = (state == S_DONE);
    rf_ra       = '0;
    rf_regwrite = 1'b0;
    rf_wa       = '0;
    rf_wd       = '0;
    case (state)
      S_IDLE: begin
        if (load_fire && (load_row != '0)) begin
          rf_regwrite = 1'b1;
          rf_wa       = load_row;
          rf_wd       = load_data;
        end
      end
      S_PRIME: rf_ra = ROW_ONE;
      S_LOAD:  rf_ra = (r == NROWS) ? '0 : r + ROW_ONE;
      S_WRITE: begin
        rf_regwrite = 1'b1;
        rf_wa       = r;
        rf_wd       = next_row;
      end
      default: ;
    endcase
  end

  // Sequencer state, row pointer, sliding window and generation counter.
  always_ff @(posedge ph2 or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      r         <= ROW_ONE;
      prev      <= '0;
      cur       <= '0;
      nxt       <= '0;
      gen_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_PRIME;
            prev  <= '0;
            r     <= ROW_ONE;
          end
        end
        S_PRIME: begin
          cur   <= rf_rd;
          state <= S_LOAD;
        end
        S_LOAD: begin
          nxt   <= rf_rd;
          state <= S_WRITE;
        end
        S_WRITE: begin
          // Old row r survives in prev, so overwriting it in the regfile is safe.
          prev <= cur;
          cur  <= nxt;
          if (r == NROWS) begin
            state <= S_DONE;
          end else begin
            r     <= r + ROW_ONE;
            state <= S_LOAD;
          end
        end
        S_DONE: begin
          gen_count <= gen_count + GENBITS'(1);
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gol_gen_sequencer.sv
// Bench for gol_gen_sequencer: two instances (dead edges / toroidal with a
// 2-bit generation counter) share stimulus, each backed by its own regfile.
// A whole-grid Life model predicts every cycle's outputs.
module tb_gol_gen_sequencer;

  logic       ph2 = 1'b0;
  logic       reset_n;
  logic       start;
  logic       load_valid;
  logic [2:0] load_row;
  logic [7:0] load_data;

  logic        busy0, done0, ready0, we0;
  logic [15:0] gen0;
  logic [2:0]  ra0, wa0;
  logic [7:0]  rd0, wd0;
  logic        busy1, done1, ready1, we1;
  logic [1:0]  gen1;
  logic [2:0]  ra1, wa1;
  logic [7:0]  rd1, wd1;

  logic [7:0] rf0 [0:7] = '{default: 8'h00};
  logic [7:0] rf1 [0:7] = '{default: 8'h00};

  int n_total = 0;
  int n_pass  = 0;

  gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .GENBITS(16), .WRAP(0)) dut0 (
    .ph2(ph2), .reset_n(reset_n), .start(start), .busy(busy0), .done(done0),
    .gen_count(gen0), .load_valid(load_valid), .load_ready(ready0),
    .load_row(load_row), .load_data(load_data), .rf_ra(ra0), .rf_rd(rd0),
    .rf_regwrite(we0), .rf_wa(wa0), .rf_wd(wd0));

  gol_gen_sequencer #(.WIDTH(8), .REGBITS(3), .GENBITS(2), .WRAP(1)) dut1 (
    .ph2(ph2), .reset_n(reset_n), .start(start), .busy(busy1), .done(done1),
    .gen_count(gen1), .load_valid(load_valid), .load_ready(ready1),
    .load_row(load_row), .load_data(load_data), .rf_ra(ra1), .rf_rd(rd1),
    .rf_regwrite(we1), .rf_wa(wa1), .rf_wd(wd1));

  always #5 ph2 = ~ph2;

  // Regfiles: row 0 reads as zero, writes land on the rising edge.
  assign rd0 = (ra0 == 3'd0) ? 8'h00 : rf0[ra0];
  assign rd1 = (ra1 == 3'd0) ? 8'h00 : rf1[ra1];
  always @(posedge ph2) begin
    if (we0) rf0[wa0] <= wd0;
    if (we1) rf1[wa1] <= wd1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Life on one row given its neighbours, by direct neighbour counting.
  function automatic logic [7:0] life_row(input logic [7:0] a, input logic [7:0] c,
                                          input logic [7:0] b, input bit wrap);
    logic [7:0] rows [3];
    logic [7:0] res;
    int n, col;
    rows[0] = a; rows[1] = c; rows[2] = b;
    res = 8'h00;
    for (int cc = 0; cc < 8; cc++) begin
      n = 0;
      for (int dr = 0; dr < 3; dr++) begin
        for (int dc = -1; dc <= 1; dc++) begin
          if (dr == 1 && dc == 0) continue;
          col = cc + dc;
          if (col < 0 || col > 7) begin
            if (!wrap) continue;
            col = (col + 8) % 8;
          end
          n += int'(rows[dr][col]);
        end
      end
      res[cc] = (n == 3) || (c[cc] && n == 2);
    end
    return res;
  endfunction

  // Model: expected grids, next-generation grids, cycle index within a generation.
  logic [7:0] m0  [0:7] = '{default: 8'h00};
  logic [7:0] m1  [0:7] = '{default: 8'h00};
  logic [7:0] nx0 [0:7] = '{default: 8'h00};
  logic [7:0] nx1 [0:7] = '{default: 8'h00};
  int m_i   = -1;
  int m_gen = 0;

  // Compare process: check on the falling edge, then step the model past the next rising edge.
  initial begin
    logic       e_busy, e_done, e_ready, e_we, chk_ra;
    logic [2:0] e_wa, e_ra;
    logic [7:0] e_wd0, e_wd1;
    int wr, lr;
    forever begin
      @(negedge ph2);
      if (!reset_n) begin
        chk("rst_busy0", busy0, 0);   chk("rst_busy1", busy1, 0);
        chk("rst_done0", done0, 0);   chk("rst_we0", we0, 0);
        chk("rst_we1", we1, 0);       chk("rst_ra0", ra0, 0);
        chk("rst_wa0", wa0, 0);       chk("rst_wd0", wd0, 0);
        chk("rst_gen0", gen0, 0);     chk("rst_gen1", gen1, 0);
        m_i = -1; m_gen = 0;
      end else begin
        wr = 0; lr = 0; e_ra = 3'd0;
        if (m_i < 0) begin
          e_busy = 0; e_done = 0; e_ready = 1; chk_ra = 0;
          e_we  = load_valid && (load_row != 3'd0);
          e_wa  = e_we ? load_row : 3'd0;
          e_wd0 = e_we ? load_data : 8'h00;
          e_wd1 = e_wd0;
        end else begin
          e_busy = 1; e_ready = 0;
          e_done = (m_i == 15);
          e_we   = (m_i >= 2) && (m_i <= 14) && (m_i % 2 == 0);
          wr     = m_i / 2;
          e_wa   = e_we ? 3'(wr) : 3'd0;
          e_wd0  = e_we ? nx0[wr] : 8'h00;
          e_wd1  = e_we ? nx1[wr] : 8'h00;
          chk_ra = (m_i == 0) || (m_i % 2 == 1 && m_i < 15);
          if (m_i == 0) e_ra = 3'd1;
          else begin
            lr   = (m_i + 1) / 2;
            e_ra = (lr == 7) ? 3'd0 : 3'(lr + 1);
          end
        end
        chk("busy0", busy0, e_busy);   chk("busy1", busy1, e_busy);
        chk("done0", done0, e_done);   chk("done1", done1, e_done);
        chk("ready0", ready0, e_ready); chk("ready1", ready1, e_ready);
        chk("we0", we0, e_we);         chk("we1", we1, e_we);
        chk("wa0", wa0, e_wa);         chk("wa1", wa1, e_wa);
        chk("wd0", wd0, e_wd0);        chk("wd1", wd1, e_wd1);
        chk("gen0", gen0, 32'(m_gen % 65536));
        chk("gen1", gen1, 32'(m_gen % 4));
        if (chk_ra) begin
          chk("ra0", ra0, e_ra); chk("ra1", ra1, e_ra);
        end
        if (m_i < 0) begin
          if (load_valid && load_row != 3'd0) begin
            m0[load_row] = load_data;
            m1[load_row] = load_data;
          end
          if (start) begin
            for (int r = 1; r <= 7; r++) begin
              nx0[r] = life_row(m0[r-1], m0[r], (r == 7) ? 8'h00 : m0[r+1], 1'b0);
              nx1[r] = life_row(m1[r-1], m1[r], (r == 7) ? 8'h00 : m1[r+1], 1'b1);
            end
            m_i = 0;
          end
        end else begin
          if (e_we) begin
            m0[wr] = nx0[wr];
            m1[wr] = nx1[wr];
          end
          if (m_i == 15) begin
            for (int r = 1; r <= 7; r++) begin
              chk($sformatf("rf0_row%0d", r), rf0[r], m0[r]);
              chk($sformatf("rf1_row%0d", r), rf1[r], m1[r]);
            end
            m_gen++;
            m_i = -1;
          end else begin
            m_i++;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge ph2);
    #1;
  endtask

  task automatic load(input int row, input logic [7:0] d);
    load_valid = 1'b1;
    load_row   = 3'(row);
    load_data  = d;
    tick();
    load_valid = 1'b0;
  endtask

  task automatic clear_all();
    for (int r = 1; r <= 7; r++) load(r, 8'h00);
  endtask

  // One generation; optionally hog the load port while busy or load in the start cycle.
  task automatic run_gen(input bit hog, input bit with_load, input int lrow,
                         input logic [7:0] ldata, output int cycles);
    start      = 1'b1;
    load_valid = with_load;
    load_row   = 3'(lrow);
    load_data  = ldata;
    tick();
    start      = 1'b0;
    load_valid = hog;
    load_row   = 3'd5;
    load_data  = 8'hFF;
    cycles = 0;
    while (busy0 && cycles <= 40) begin
      cycles++;
      tick();
    end
    load_valid = 1'b0;
    if (cycles > 40) chk("gen_timeout", busy0, 0);
  endtask

  initial begin
    int cyc, nd, last;
    reset_n = 1'b0; start = 1'b0; load_valid = 1'b0;
    load_row = 3'd0; load_data = 8'h00;
    repeat (3) tick();
    reset_n = 1'b1;
    tick();
    chk("idle_ready", ready0, 1);

    // Blinker oscillates.
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    run_gen(0, 0, 0, 8'h00, cyc);
    chk("busy_len", cyc, 16);
    chk("blink_r3", rf0[3], 8'h1C); chk("blink_r2", rf0[2], 8'h00);
    chk("blink_r4", rf0[4], 8'h00); chk("blink_gen", gen0, 1);
    run_gen(0, 0, 0, 8'h00, cyc);
    chk("blink2_r2", rf0[2], 8'h08); chk("blink2_r3", rf0[3], 8'h08);
    chk("blink2_r4", rf0[4], 8'h08); chk("blink2_gen", gen0, 2);

    // Block is still life; edge block survives only when toroidal.
    clear_all();
    load(1, 8'h03); load(2, 8'h03);
    run_gen(0, 0, 0, 8'h00, cyc);
    chk("block_r1", rf0[1], 8'h03); chk("block_r2", rf0[2], 8'h03);
    clear_all();
    load(3, 8'h81); load(4, 8'h81);
    run_gen(0, 0, 0, 8'h00, cyc);
    chk("wrap_r3", rf1[3], 8'h81); chk("wrap_r4", rf1[4], 8'h81);
    chk("nowrap_r3", rf0[3], 8'h00); chk("nowrap_r4", rf0[4], 8'h00);

    // Bottom boundary: row below the last row is dead.
    clear_all();
    load(7, 8'h1C);
    run_gen(0, 0, 0, 8'h00, cyc);
    chk("bot_r6", rf0[6], 8'h08); chk("bot_r7", rf0[7], 8'h08);
    chk("bot_r5", rf0[5], 8'h00);

    // Host hogging the load port while busy is ignored.
    clear_all();
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    run_gen(1, 0, 0, 8'h00, cyc);
    chk("hog_len", cyc, 16);
    chk("hog_r5", rf0[5], 8'h00); chk("hog_r3", rf0[3], 8'h1C);
    load(0, 8'hFF);

    // Load in the start cycle is seen by PRIME.
    clear_all();
    load(2, 8'h08); load(3, 8'h08);
    run_gen(0, 1, 1, 8'h08, cyc);
    chk("same_r2", rf0[2], 8'h1C); chk("same_r1", rf0[1], 8'h00);

    // Reset in the 5th busy cycle.
    clear_all();
    load(2, 8'h08); load(3, 8'h08); load(4, 8'h08);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    reset_n = 1'b0;
    #1;
    chk("mid_busy", busy0, 0); chk("mid_done", done0, 0);
    chk("mid_we", we0, 0);     chk("mid_gen", gen0, 0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk("post_ready", ready0, 1); chk("post_busy", busy0, 0);
    chk("post_r2", rf0[2], 8'h08);

    // Randomized loads and generations.
    for (int k = 0; k < 30; k++) begin
      case ($urandom_range(3, 0))
        0, 1: load(int'($urandom_range(7, 0)), 8'($urandom));
        2: run_gen(1'($urandom), 0, 0, 8'h00, cyc);
        default: run_gen(0, 1, int'($urandom_range(7, 0)), 8'($urandom), cyc);
      endcase
      if ($urandom_range(1, 0) == 1) tick();
    end

    // start held high: back-to-back generations, 2-bit counter wraps.
    reset_n = 1'b0; tick(); reset_n = 1'b1; tick();
    cyc = 0; nd = 0; last = -1;
    start = 1'b1;
    while (nd < 4 && cyc < 120) begin
      tick(); cyc++;
      if (done1) begin
        if (last >= 0) chk("b2b_period", cyc - last, 17);
        last = cyc;
        nd++;
        tick(); cyc++;
        chk("b2b_gen1", gen1, 32'(nd % 4));
      end
    end
    start = 1'b0;
    if (nd < 4) chk("b2b_timeout", nd, 4);
    cyc = 0;
    while (busy0 && cyc < 40) begin
      tick(); cyc++;
    end
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
